list_pop_scheduler: RTL and testbench
=====================================

Name: list_pop_scheduler

Overview:
- Pop-side controller for the 21-list linked-list buffer: chooses which list to pop each cycle from the buffer's per-list valid bitmap, drives the buffer's pop port, and registers the popped head entry into a one-deep output stage with valid/ready handshake.
- Round-robin across lists, with bounded bursts on one list; per-list block mask from downstream credit logic.

Parameters:
- NUM_LISTS, 21, number of lists (width of valid/block vectors)
- IDX_W, 5, list index width, ceil(log2(NUM_LISTS))
- DATA_W, 48, width of popped entry payload
- BURST_MAX, 4, max consecutive pops from one list before forced rotation (1..2^CNT_W-1)
- CNT_W, 3, burst counter width

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- enable  in  1  scheduling allowed when 1
- list_valid  in  NUM_LISTS  per-list non-empty bitmap from buffer
- list_block  in  NUM_LISTS  per-list inhibit; 1 = do not pop this list
- pop_valid  out  1  pop strobe to buffer (combinational)
- pop_bits  out  IDX_W  list index to pop (combinational)
- pop_data  in  DATA_W  head entry of list pop_bits, valid same cycle
- out_valid  out  1  output stage holds an entry
- out_ready  in  1  downstream accepts
- out_index  out  IDX_W  list the held entry came from
- out_data  out  DATA_W  held entry
- busy  out  1  state == LOCK or out_valid

Behaviour:
- Reset (reset==0, async): state=IDLE, rr_ptr=0, cur=0, cnt=0, out_valid=0, out_index=0, out_data=0; pop_valid forced 0, pop_bits=0 while asserted.
- eligible = list_valid & ~list_block. can_accept = ~out_valid | out_ready.
- pop fires (pop_valid=1) only when enable & can_accept & target eligible; never otherwise. pop_bits = target when pop_valid, else cur.
- States: IDLE, LOCK.
  - IDLE: target = first eligible index at or above rr_ptr, wrapping modulo NUM_LISTS. On fire: cur<=target, cnt<=1, go LOCK unless BURST_MAX==1 or target will be empty (see below); rr_ptr<=target+1 (wrap NUM_LISTS-1 -> 0) on exit from lock.
  - LOCK: target = cur. Fires when eligible[cur] & can_accept & enable; on fire cnt<=cnt+1.
  - LOCK -> IDLE, rr_ptr<=cur+1 (wrap), cnt<=0, when any: fire with cnt+1==BURST_MAX; eligible[cur]==0 (empty or blocked) — exit same cycle, no pop that cycle; enable==0.
  - Lock hold when ~can_accept and eligible[cur]: stay LOCK, no pop, cnt unchanged.
- list_valid deasserts the cycle after the last entry pops (buffer updates on clock); a re-pop of a list the cycle after its last pop cannot occur because list_valid is sampled combinationally from the already-updated bitmap.
- Output stage: on fire, out_valid<=1, out_data<=pop_data, out_index<=target (1-cycle latency). Else if out_ready: out_valid<=0. Simultaneous out_ready and fire: replace entry, out_valid stays 1 (full throughput, one pop per cycle).
- out_data/out_index stable while out_valid & ~out_ready.
- rr_ptr only advances on lock exit; no eligible list -> stay IDLE, pop_valid=0.
- Reset mid-burst: all state cleared immediately; the in-flight output entry is discarded.
- enable deassert: no new pop from that cycle; output stage still drains.

Test Plan:
- Reset: hold reset=0 with list_valid=all ones -> pop_valid=0, out_valid=0, busy=0; release -> first pop_bits=0 next edge-evaluated cycle.
- Burst/rotate: lists 3 and 7 non-empty (10 entries each), out_ready=1, BURST_MAX=4 -> pop order 3,3,3,3,7,7,7,7,3,... one pop per cycle, out_index follows one cycle later.
- Empty early exit: list 5 has 2 entries, list 9 has 5 -> pops 5,5, then 9x4; rr_ptr=10 after list 9 lock.
- Backpressure: out_ready=0 after first pop -> pop_valid=0, out_data/out_index held; out_ready=1 -> next pop same cycle, no entry lost or duplicated.
- Block: list_block[3] asserted mid-burst on list 3 after 2 pops -> exit to IDLE, next pop list 7; deassert -> list 3 served on its next round-robin turn.
- Wrap: only list 20 and 0 eligible, rr_ptr=20 -> pops 20 (burst), then 0; rr_ptr wraps 20 -> 0 -> 1.

Source files
------------

// File: rtl/list_pop_scheduler.sv
// Pop-side scheduler for the multi-list linked-list buffer: round-robin list selection with
// bounded per-list bursts, buffer pop strobe, and a one-deep valid/ready output register.
module list_pop_scheduler #(
  parameter int unsigned NUM_LISTS = 21,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned DATA_W    = 48,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_LISTS-1:0] list_valid,
  input  logic [NUM_LISTS-1:0] list_block,
  output logic                 pop_valid,
  output logic [IDX_W-1:0]     pop_bits,
  input  logic [DATA_W-1:0]    pop_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_index,
  output logic [DATA_W-1:0]    out_data,
  output logic                 busy
);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q;
  logic [IDX_W-1:0]   out_index_q;
  logic [DATA_W-1:0]  out_data_q;

  logic [NUM_LISTS-1:0] eligible;
  logic                 can_accept;
  logic                 rr_found;
  logic [IDX_W-1:0]     rr_idx;
  logic [IDX_W-1:0]     cand;
  int                   rr_scan;
  logic [IDX_W-1:0]     target;
  logic                 target_ok;
  logic                 fire;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_LISTS - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  assign eligible   = list_valid & ~list_block;
  assign can_accept = ~out_valid_q | out_ready;

  // First eligible list at or above rr_ptr, wrapping modulo NUM_LISTS.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_scan  = 0;
    cand     = '0;
    for (int k = 0; k < int'(NUM_LISTS); k++) begin
      rr_scan = int'(rr_ptr_q) + k;
      if (rr_scan >= int'(NUM_LISTS)) rr_scan = rr_scan - int'(NUM_LISTS);
      cand = IDX_W'(rr_scan);
      if (!rr_found && eligible[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  always_comb begin
    if (state_q == StLock) begin
      target    = cur_q;
      target_ok = eligible[cur_q];
    end else begin
      target    = rr_idx;
      target_ok = rr_found;
    end
  end

  assign fire      = enable & can_accept & target_ok;
  assign pop_valid = fire & reset;
  assign pop_bits  = pop_valid ? target : cur_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (fire) begin
          cur_d = target;
          if (BURST_MAX == 1) begin
            rr_ptr_d = next_idx(target);
          end else begin
            state_d = StLock;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      StLock: begin
        // Empty, blocked or disabled lists release the lock without popping this cycle.
        if (!enable || !eligible[cur_q]) begin
          state_d  = StIdle;
          rr_ptr_d = next_idx(cur_q);
          cnt_d    = '0;
        end else if (fire) begin
          if (cnt_q + CNT_W'(1) == CNT_W'(BURST_MAX)) begin
            state_d  = StIdle;
            rr_ptr_d = next_idx(cur_q);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
    end
  end

  // A new pop may overwrite the held entry in the same cycle it is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      out_index_q <= target;
      out_data_q  <= pop_data;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == StLock) | out_valid_q;

endmodule

// File: tb/tb_list_pop_scheduler.sv
// Directed bench for list_pop_scheduler: a per-list entry-count buffer model feeds the DUT,
// a vector table checks cycle behaviour, and short sequences check pop order and reset.
module tb_list_pop_scheduler;
  localparam int NL = 21;
  localparam int IW = 5;
  localparam int DW = 48;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [NL-1:0] list_valid;
  logic [NL-1:0] list_block = '0;
  logic          pop_valid;
  logic [IW-1:0] pop_bits;
  logic [DW-1:0] pop_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_index;
  logic [DW-1:0] out_data;
  logic          busy;

  list_pop_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .list_valid (list_valid),
    .list_block (list_block),
    .pop_valid  (pop_valid),
    .pop_bits   (pop_bits),
    .pop_data   (pop_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Buffer model: entries remaining per list; head payload is {list, remaining count}.
  int cnt_m [NL];

  always_comb begin
    for (int i = 0; i < NL; i++) list_valid[i] = (cnt_m[i] != 0);
  end

  always_comb begin
    pop_data = '0;
    if (pop_bits < IW'(NL)) pop_data = {8'(pop_bits), 40'(cnt_m[pop_bits])};
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic          obs_pv, obs_ov, obs_busy;
  logic [IW-1:0] obs_pb, obs_oi;
  logic          exp_ov;
  logic [DW-1:0] exp_od;
  logic [IW-1:0] exp_oi;
  int            pops[$];

  typedef struct {
    logic          en;
    logic          blk3;
    logic          rdy;
    logic          pv;
    logic [IW-1:0] pb;
    logic          ov;
    logic [IW-1:0] oi;
    logic          bsy;
  } vec_t;

  vec_t vecs [20];
  int   exp_empty [7] = '{5, 5, 9, 9, 9, 9, 9};
  int   exp_wrap [10] = '{19, 20, 20, 20, 20, 0, 0, 0, 20, 20};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // One clock: sample at negedge, score the output stage, update models after the edge.
  task automatic step();
    logic          rdy;
    logic [DW-1:0] nxt;
    nxt = '0;
    @(negedge clock);
    obs_pv   = pop_valid;
    obs_pb   = pop_bits;
    obs_ov   = out_valid;
    obs_oi   = out_index;
    obs_busy = busy;
    check("sb_out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      check("sb_out_data", 64'(out_data), 64'(exp_od));
      check("sb_out_index", 64'(out_index), 64'(exp_oi));
    end
    if (obs_pv) begin
      pops.push_back(int'(obs_pb));
      nxt = {8'(obs_pb), 40'(cnt_m[obs_pb])};
    end
    rdy = out_ready;
    @(posedge clock);
    #1;
    if (obs_pv) begin
      exp_ov = 1'b1;
      exp_od = nxt;
      exp_oi = obs_pb;
      cnt_m[obs_pb] = cnt_m[obs_pb] - 1;
    end else if (rdy) begin
      exp_ov = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    enable     = 1'b1;
    out_ready  = 1'b1;
    list_block = '0;
    for (int i = 0; i < NL; i++) cnt_m[i] = 0;
    exp_ov = 1'b0;
    exp_od = '0;
    exp_oi = '0;
    pops.delete();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //           en blk3 rdy | pv pb ov oi busy
    vecs[0]  = '{1, 0, 1, 1, 3, 0, 0, 0};
    vecs[1]  = '{1, 0, 1, 1, 3, 1, 3, 1};
    vecs[2]  = '{1, 0, 1, 1, 3, 1, 3, 1};
    vecs[3]  = '{1, 0, 1, 1, 3, 1, 3, 1};
    vecs[4]  = '{1, 0, 1, 1, 7, 1, 3, 1};
    vecs[5]  = '{1, 0, 1, 1, 7, 1, 7, 1};
    vecs[6]  = '{1, 0, 1, 1, 7, 1, 7, 1};
    vecs[7]  = '{1, 0, 1, 1, 7, 1, 7, 1};
    vecs[8]  = '{1, 0, 1, 1, 3, 1, 7, 1};
    vecs[9]  = '{1, 0, 1, 1, 3, 1, 3, 1};
    vecs[10] = '{1, 1, 1, 0, 3, 1, 3, 1};
    vecs[11] = '{1, 1, 1, 1, 7, 0, 3, 0};
    vecs[12] = '{1, 0, 1, 1, 7, 1, 7, 1};
    vecs[13] = '{1, 0, 0, 0, 7, 1, 7, 1};
    vecs[14] = '{1, 0, 0, 0, 7, 1, 7, 1};
    vecs[15] = '{1, 0, 1, 1, 7, 1, 7, 1};
    vecs[16] = '{1, 0, 1, 1, 7, 1, 7, 1};
    vecs[17] = '{1, 0, 1, 1, 3, 1, 7, 1};
    vecs[18] = '{0, 0, 1, 0, 3, 1, 3, 1};
    vecs[19] = '{0, 0, 1, 0, 3, 0, 3, 0};

    // Reset held with every list non-empty.
    do_reset();
    for (int i = 0; i < NL; i++) cnt_m[i] = 3;
    #2;
    check("rst_pop_valid", 64'(pop_valid), 64'd0);
    check("rst_pop_bits", 64'(pop_bits), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    step();
    check("rel_pop_valid", 64'(obs_pv), 64'd1);
    check("rel_pop_bits", 64'(obs_pb), 64'd0);
    step();
    // Asynchronous reset mid-burst drops the held entry immediately.
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_pop_valid", 64'(pop_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);

    // Burst/rotate, block mid-burst, backpressure and enable drop.
    do_reset();
    cnt_m[3] = 10;
    cnt_m[7] = 10;
    reset = 1'b1;
    for (int r = 0; r < 20; r++) begin
      enable     = vecs[r].en;
      list_block = vecs[r].blk3 ? NL'(8) : '0;
      out_ready  = vecs[r].rdy;
      step();
      check($sformatf("v%0d_pop_valid", r), 64'(obs_pv), 64'(vecs[r].pv));
      check($sformatf("v%0d_pop_bits", r), 64'(obs_pb), 64'(vecs[r].pb));
      check($sformatf("v%0d_out_valid", r), 64'(obs_ov), 64'(vecs[r].ov));
      check($sformatf("v%0d_out_index", r), 64'(obs_oi), 64'(vecs[r].oi));
      check($sformatf("v%0d_busy", r), 64'(obs_busy), 64'(vecs[r].bsy));
    end

    // Lock releases early on an emptied list.
    do_reset();
    cnt_m[5] = 2;
    cnt_m[9] = 5;
    reset = 1'b1;
    repeat (12) step();
    check("empty_npops", 64'(pops.size()), 64'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < pops.size()) check($sformatf("empty_pop%0d", i), 64'(pops[i]), 64'(exp_empty[i]));
    end

    // Round-robin pointer wraps from the top list back to list 0.
    do_reset();
    cnt_m[19] = 1;
    cnt_m[20] = 6;
    cnt_m[0]  = 3;
    list_block = NL'(21'h1FFFFF ^ (21'h1 << 19));
    reset = 1'b1;
    step();
    step();
    list_block = '0;
    repeat (14) step();
    check("wrap_npops", 64'(pops.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < pops.size()) check($sformatf("wrap_pop%0d", i), 64'(pops[i]), 64'(exp_wrap[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
